// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: game state encodings
// and overlay colours used by the top-level colour mux.
package breakout_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT   = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_MISS_WAIT = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    localparam logic [11:0] COL_BLANK     = 12'h000;
    localparam logic [11:0] COL_ATTRACT   = 12'hFFF;
    localparam logic [11:0] COL_GAME_OVER = 12'hF00;
    localparam logic [11:0] COL_WIN       = 12'h0F0;

    function automatic logic isEndState(input state_t s);
        return (s == ST_GAME_OVER) || (s == ST_WIN);
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous button
// followed by a registered one-cycle rising-edge pulse.
module btn_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic pulse
);

    logic [1:0] sync;
    logic       prev;

    // Synchronize, remember last level, emit pulse on 0->1
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], button};
            prev  <= sync[1];
            pulse <= sync[1] & ~prev;
        end
    end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: serve/play/miss/end states,
// lives, score, bricks remaining and end-screen blink.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int LIVES_W      = 2,
    parameter int SCORE_W      = 10,
    parameter int BRICKS       = 40,
    parameter int MISS_FRAMES  = 60,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btnC,
    input  logic               brick_hit,
    input  logic               ball_miss,
    output logic               paddle_en,
    output logic               ball_en,
    output logic               ball_rst,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         game_state,
    output logic               blink
);

    localparam int BW   = $clog2(BRICKS + 1);
    localparam int FMAX = (MISS_FRAMES > BLINK_FRAMES) ? MISS_FRAMES : BLINK_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    localparam logic [FW-1:0]      MISS_LAST   = FW'(MISS_FRAMES - 1);
    localparam logic [FW-1:0]      BLINK_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0]      BRICKS_LOAD = BW'(BRICKS);
    localparam logic [LIVES_W-1:0] LIVES_LOAD  = LIVES_W'(LIVES_INIT);

    state_t         state;
    state_t         stateNext;
    logic [BW-1:0]  bricksLeft;
    logic [FW-1:0]  frameCnt;
    logic           start;
    logic           lastBrick;
    logic           reload;
    logic           frameCounting;

    btn_edge_sync uStart (
        .clock  (clock),
        .reset  (reset),
        .button (btnC),
        .pulse  (start)
    );

    assign game_state    = state;
    assign reload        = start && (state == ST_ATTRACT || isEndState(state));
    assign frameCounting = (state == ST_MISS_WAIT) || isEndState(state);

    // Next-state selection and Moore output decode
    always_comb begin
        stateNext = state;
        lastBrick = 1'b0;
        paddle_en = 1'b0;
        ball_en   = 1'b0;
        ball_rst  = 1'b1;
        unique case (state)
            ST_ATTRACT: begin
                if (start) stateNext = ST_SERVE;
            end
            ST_SERVE: begin
                paddle_en = 1'b1;
                if (start) stateNext = ST_PLAY;
            end
            ST_PLAY: begin
                paddle_en = 1'b1;
                ball_en   = 1'b1;
                ball_rst  = 1'b0;
                lastBrick = brick_hit && (bricksLeft == BW'(1));
                if (lastBrick)
                    stateNext = ST_WIN;
                else if (ball_miss)
                    stateNext = (lives == LIVES_W'(1)) ? ST_GAME_OVER : ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (frame_tick && frameCnt == MISS_LAST) stateNext = ST_SERVE;
            end
            ST_GAME_OVER, ST_WIN: begin
                if (start) stateNext = ST_SERVE;
            end
            default: stateNext = ST_ATTRACT;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= ST_ATTRACT;
        else        state <= stateNext;
    end

    // Lives, score and bricks: reload on new game, update in play
    always_ff @(posedge clock) begin
        if (!reset) begin
            lives      <= LIVES_LOAD;
            score      <= '0;
            bricksLeft <= BRICKS_LOAD;
        end else if (reload) begin
            lives      <= LIVES_LOAD;
            score      <= '0;
            bricksLeft <= BRICKS_LOAD;
        end else if (state == ST_PLAY) begin
            if (brick_hit) begin
                if (score != '1)      score      <= score + SCORE_W'(1);
                if (bricksLeft != '0) bricksLeft <= bricksLeft - BW'(1);
            end
            if (ball_miss && !lastBrick && lives != '0)
                lives <= lives - LIVES_W'(1);
        end
    end

    // Frame counter and end-screen blink phase
    always_ff @(posedge clock) begin
        if (!reset) begin
            frameCnt <= '0;
            blink    <= 1'b0;
        end else begin
            if (stateNext != state) begin
                frameCnt <= '0;
            end else if (frame_tick && frameCounting) begin
                if (isEndState(state) && frameCnt == BLINK_LAST) begin
                    frameCnt <= '0;
                    blink    <= ~blink;
                end else begin
                    frameCnt <= frameCnt + FW'(1);
                end
            end
            if (!isEndState(stateNext)) blink <= 1'b0;
        end
    end

endmodule
